dlsc_domaincross_rvh_arb: RTL and testbench
===========================================

Name: dlsc_domaincross_rvh_arb

Overview:
- Round-robin arbiter that shares one ready/valid/hold (rvh) channel between INPUTS requesters in a single clock domain.
- Typically sits directly upstream of a domain-crossing rvh block; its out_* port drives that block's in_* port.
- Each accepted beat goes into a single registered output stage, tagged with the index of the requester that sourced it.
- Sustains one beat per clock when the consumer is always ready.

Parameters:
- INPUTS, 4, number of requesters (2..16).
- DATA, 32, payload width per requester.
- ID, 2, width of out_id; must satisfy 2**ID >= INPUTS.
- RESET, {DATA{1'b0}}, value of out_data while in reset.

Ports:
- clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- in_ready  output  INPUTS  per-requester accept; bit i=1 means beat i is taken this cycle.
- in_valid  input  INPUTS  per-requester valid.
- in_data  input  INPUTS*DATA  requester i occupies bits [i*DATA +: DATA].
- out_ready  input  1  downstream accept.
- out_valid  output  1  registered output stage holds a beat.
- out_data  output  DATA  registered payload.
- out_id  output  ID  registered index of the requester that sourced out_data.

Behaviour:
- Reset (asynchronous assert, release on clk):
  - out_valid=0, out_data=RESET, out_id=0.
  - Priority pointer = 0, so requester 0 has highest priority on the first grant.
  - in_ready=0 while rst is asserted.
- Output stage:
  - can_load = !out_valid || out_ready.
  - The output stage loads on any cycle where can_load=1 and at least one in_valid bit is 1.
- Grant (combinational):
  - Scan in_valid starting at the pointer and wrapping modulo INPUTS; the first set bit wins.
  - in_ready = one-hot of the winner when can_load=1, else all zero.
  - in_ready depends on in_valid. No other requester sees ready in that cycle.
- On grant of requester g (registered):
  - out_data <= in_data[g], out_id <= g, out_valid <= 1.
  - Pointer <= (g+1) mod INPUTS.
- Pointer behaviour:
  - The pointer changes only on a grant; an idle cycle leaves it unchanged.
  - Wrap: g=INPUTS-1 sets pointer to 0. Non-power-of-2 INPUTS must wrap correctly.
- Consumer handshake:
  - out_valid && out_ready with no new grant: out_valid <= 0. out_data and out_id keep their values.
  - Simultaneous drain and load (out_valid=1, out_ready=1, grant present): back-to-back transfer with no bubble.
- Latency: 1 clk from in_valid&&in_ready to out_valid.
- Throughput: 1 beat/clk.
- Hold rules:
  - Requesters keep in_valid and in_data stable until they see in_ready.
  - The block keeps out_valid, out_data and out_id stable until out_ready.
  - out_valid never drops without a handshake.
- Fairness: with every requester valid continuously, grants rotate 0,1,...,INPUTS-1,0,...; no requester waits more than INPUTS-1 grants.
- Reset mid-operation: any beat in the output stage is discarded, out_valid=0 immediately, pointer returns to 0.

Optional Feature:
- Macro: DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN.
- With the macro defined:
  - Adds input port in_last, width INPUTS.
  - After requester g is granted a beat with in_last[g]=0, the arbiter is locked to g. Only g can be granted until a beat of g with in_last[g]=1 is accepted.
  - While locked, other requesters see in_ready=0 even if g is idle.
  - The pointer advances only on acceptance of the beat with in_last=1.
  - Reset clears the lock.
- Without the macro: no in_last port; the arbiter re-arbitrates on every beat.

Test Plan:
- Reset, then INPUTS=4 with all in_valid=1 and out_ready=1 → out_id sequence 0,1,2,3,0 on consecutive clks, one beat/clk, no bubbles.
- Only requester 2 valid with in_data=0xA5A5A5A5 → in_ready=4'b0100, next clk out_valid=1, out_data=0xA5A5A5A5, out_id=2. Pointer=3, so when requesters 0 and 3 then raise valid together, 3 wins first.
- Hold out_ready=0 for 5 clks with a beat in the output stage and requesters valid → in_ready=0 and out_data/out_id stable for all 5 clks. Release out_ready → the next beat loads on the same clk as the drain.
- INPUTS=3, ID=2, all valid → grants wrap 0,1,2,0; out_id never equals 3.
- Assert rst asynchronously mid-stream with out_valid=1 → out_valid=0 and out_data=RESET before the next clk edge. The first grant after release goes to requester 0.
- LOCK_EN defined, requester 1 sends 3 beats (in_last on beat 3) while requester 0 stays valid → out_id=1,1,1 then 0.

Source files
------------

// File: rtl/dlsc_domaincross_rvh_arb.sv
// Round-robin arbiter merging INPUTS ready/valid/hold requesters into one registered output stage.
// Optional packet lock (in_last) enabled by defining DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN.
module dlsc_domaincross_rvh_arb #(
    parameter int              INPUTS = 4,
    parameter int              DATA   = 32,
    parameter int              ID     = 2,
    parameter logic [DATA-1:0] RESET  = {DATA{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [INPUTS-1:0]      in_ready,
    input  logic [INPUTS-1:0]      in_valid,
`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
    input  logic [INPUTS-1:0]      in_last,
`endif
    input  logic [INPUTS*DATA-1:0] in_data,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA-1:0]        out_data,
    output logic [ID-1:0]          out_id
);

    logic            out_valid_q, out_valid_d;
    logic [DATA-1:0] out_data_q, out_data_d;
    logic [ID-1:0]   out_id_q, out_id_d;
    logic [ID-1:0]   ptr_q, ptr_d;

    logic            can_load;
    logic            any_vld;
    logic            fire;
    logic [ID-1:0]   gnt;
    logic [ID-1:0]   ptr_inc;
    logic [DATA-1:0] data_sel;

`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
    logic            lock_q, lock_d;
    logic [ID-1:0]   lock_id_q, lock_id_d;
    logic            last_sel;
`endif

    // Winner is the valid requester with the smallest distance from the pointer.
    always_comb begin
        int best;
        int off;
        best     = INPUTS;
        off      = 0;
        any_vld  = 1'b0;
        gnt      = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (in_valid[i]) begin
                off = i - int'(ptr_q);
                if (off < 0) off = off + INPUTS;
                if (off < best) begin
                    best    = off;
                    gnt     = ID'(i);
                    any_vld = 1'b1;
                end
            end
        end
`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
        // A locked packet owns the channel even while its source is idle.
        if (lock_q) begin
            gnt     = lock_id_q;
            any_vld = 1'b0;
            for (int i = 0; i < INPUTS; i++) begin
                if (int'(lock_id_q) == i) any_vld = in_valid[i];
            end
        end
`endif
    end

    always_comb begin
        can_load = !out_valid_q || out_ready;
        fire     = can_load && any_vld && !rst;
        data_sel = '0;
        in_ready = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (int'(gnt) == i) begin
                data_sel    = in_data[i*DATA +: DATA];
                in_ready[i] = fire;
            end
        end
        ptr_inc = (int'(gnt) == INPUTS-1) ? '0 : gnt + ID'(1);
    end

`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
    always_comb begin
        last_sel = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (int'(gnt) == i) last_sel = in_last[i];
        end
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
        lock_d      = lock_q;
        lock_id_d   = lock_id_q;
`endif
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = data_sel;
            out_id_d    = gnt;
`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
            if (last_sel) begin
                lock_d = 1'b0;
                ptr_d  = ptr_inc;
            end else begin
                lock_d    = 1'b1;
                lock_id_d = gnt;
            end
`else
            ptr_d       = ptr_inc;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= RESET;
            out_id_q    <= '0;
            ptr_q       <= '0;
`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_dlsc_domaincross_rvh_arb.sv
// Directed bench for dlsc_domaincross_rvh_arb: a 4-input and a 3-input instance on a shared clock/reset.
module tb_dlsc_domaincross_rvh_arb;

    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    in_ready, in_valid, in_last;
    logic [DW-1:0]   lane [N];
    logic [N*DW-1:0] in_data;
    logic            out_ready, out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;

    logic [2:0]      in_ready3, in_valid3;
    logic [3*DW-1:0] in_data3;
    logic            out_ready3, out_valid3;
    logic [DW-1:0]   out_data3;
    logic [1:0]      out_id3;

    assign in_data  = {lane[3], lane[2], lane[1], lane[0]};
    assign in_data3 = {32'h0000_3332, 32'h0000_3331, 32'h0000_3330};

    dlsc_domaincross_rvh_arb #(.INPUTS(N), .DATA(DW), .ID(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .in_valid  (in_valid),
`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
        .in_last   (in_last),
`endif
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    logic [2:0] in_last3;
    assign in_last3 = 3'b111;

    dlsc_domaincross_rvh_arb #(.INPUTS(3), .DATA(DW), .ID(2)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready3),
        .in_valid  (in_valid3),
`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
        .in_last   (in_last3),
`endif
        .in_data   (in_data3),
        .out_ready (out_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_id    (out_id3)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int id, input logic [31:0] d);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_id"},    64'(out_id),    64'(id));
        check({tag, "_data"},  64'(out_data),  64'(d));
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 4'hF;
        in_last    = 4'hF;
        out_ready  = 1'b1;
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;
        for (int i = 0; i < N; i++) lane[i] = dat(i);

        // reset state; in_ready stays low even with all requesters valid
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_id",    64'(out_id),    64'd0);
        check("rst_ready", 64'(in_ready),  64'd0);

        tick();
        rst = 1'b0;
        #1;
        check("rr_ready0", 64'(in_ready), 64'b0001);

        // all valid: grants rotate 0,1,2,3,0 without bubbles
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_out($sformatf("rr%0d", k), k % 4, dat(k % 4));
            check($sformatf("rr%0d_ready", k), 64'(in_ready), 64'(4'b0001 << ((k + 1) % 4)));
        end

        // idle: drain, data/id held
        in_valid = 4'b0000;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_id",    64'(out_id),    64'd0);
        check("drain_data",  64'(out_data),  64'(dat(0)));

        // single requester 2, then 0 and 3 together with pointer at 3
        lane[2]  = 32'hA5A5_A5A5;
        in_valid = 4'b0100;
        #1;
        check("solo_ready", 64'(in_ready), 64'b0100);
        tick();
        expect_out("solo", 2, 32'hA5A5_A5A5);
        in_valid = 4'b1001;
        #1;
        check("ptr3_ready", 64'(in_ready), 64'b1000);
        tick();
        expect_out("ptr3", 3, dat(3));
        check("ptr0_ready", 64'(in_ready), 64'b0001);
        tick();
        expect_out("ptr0", 0, dat(0));

        // backpressure for 5 clocks, then drain and load on the same edge
        out_ready = 1'b0;
        in_valid  = 4'hF;
        lane[2]   = dat(2);
        #1;
        check("stall_ready_pre", 64'(in_ready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stall%0d_ready", c), 64'(in_ready), 64'd0);
            expect_out($sformatf("stall%0d", c), 0, dat(0));
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", 64'(in_ready), 64'b0010);
        tick();
        expect_out("release", 1, dat(1));

        // asynchronous reset mid-stream
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data",  64'(out_data),  64'd0);
        check("arst_id",    64'(out_id),    64'd0);
        check("arst_ready", 64'(in_ready),  64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'b0001);
        tick();
        expect_out("post_rst", 0, dat(0));
        in_valid = 4'b0000;

        // three requesters: wrap 0,1,2,0,1
        in_valid3 = 3'b111;
        #1;
        check("n3_ready0", 64'(in_ready3), 64'b001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("n3_%0d_valid", k), 64'(out_valid3), 64'd1);
            check($sformatf("n3_%0d_id", k),    64'(out_id3),    64'(k % 3));
            check($sformatf("n3_%0d_data", k),  64'(out_data3),  64'(32'h3330 + 32'(k % 3)));
            check($sformatf("n3_%0d_ready", k), 64'(in_ready3),  64'(3'b001 << ((k + 1) % 3)));
        end
        in_valid3 = 3'b000;

`ifdef DLSC_DOMAINCROSS_RVH_ARB_LOCK_EN
        // packet lock: requester 1 sends 3 beats while requester 0 waits
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_last  = 4'hF;
        in_valid = 4'b0001;
        tick();
        expect_out("lk_pre", 0, dat(0));
        in_valid = 4'b0011;
        in_last  = 4'b0001;
        #1;
        check("lk_b1_ready", 64'(in_ready), 64'b0010);
        tick();
        expect_out("lk_b1", 1, dat(1));
        in_valid = 4'b0001;
        #1;
        check("lk_idle_ready", 64'(in_ready), 64'd0);
        tick();
        check("lk_idle_valid", 64'(out_valid), 64'd0);
        in_valid = 4'b0011;
        #1;
        check("lk_b2_ready", 64'(in_ready), 64'b0010);
        tick();
        expect_out("lk_b2", 1, dat(1));
        in_last = 4'b0011;
        #1;
        check("lk_b3_ready", 64'(in_ready), 64'b0010);
        tick();
        expect_out("lk_b3", 1, dat(1));
        check("lk_after_ready", 64'(in_ready), 64'b0001);
        tick();
        expect_out("lk_after", 0, dat(0));
        in_valid = 4'b0000;
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
